// File: rtl/multislope_pkg.sv
// Shared types and constants for the multi-slope rundown/residue sequencer.
package multislope_pkg;

  localparam int unsigned PHW  = 2;
  localparam int unsigned ERRW = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNDOWN = 2'd1,
    S_RES     = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [ERRW-1:0] ERR_NONE         = 3'd0;
  localparam logic [ERRW-1:0] ERR_SIGN         = 3'd1;
  localparam logic [ERRW-1:0] ERR_RD_TMO       = 3'd2;
  localparam logic [ERRW-1:0] ERR_RES_TMO_BASE = 3'd3;

  // Comparator level on which residue phase ph keeps integrating.
  function automatic logic cont_level(input logic [PHW-1:0] ph);
    return ph[0];
  endfunction

endpackage

// File: rtl/slope_phase_counter.sv
// Saturating phase counter with clear, load-one and increment controls.
module slope_phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max_c
);

  logic [W-1:0] cnt_d, cnt_q;

  assign at_max_c = &cnt_q;
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld1) begin
      cnt_d = W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max_c) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multislope_rundown_seq.sv
// Rundown/residue sequencer: times the main rundown and NRES alternating
// residue phases from the zero-crossing comparator and hands results off.
module multislope_rundown_seq
  import multislope_pkg::*;
#(
  parameter int unsigned NRES  = 3,
  parameter int unsigned CNTW  = 12,
  parameter int unsigned RCNTW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    zero_cmp,
  output logic                    sw_rundown,
  output logic [NRES-1:0]         sw_res,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNTW-1:0]         rd_cnt,
  output logic [NRES*RCNTW-1:0]   res_cnt,
  output logic [ERRW-1:0]         err,
  output logic                    overrun
);

  state_e state_d, state_q;
  logic [PHW-1:0]  ph_d, ph_q;
  logic [ERRW-1:0] err_w_d, err_w_q;

  logic                  sw_rundown_d, sw_rundown_q;
  logic [NRES-1:0]       sw_res_d, sw_res_q;
  logic                  busy_d, busy_q;
  logic                  out_valid_d, out_valid_q;
  logic [CNTW-1:0]       rd_cnt_d, rd_cnt_q;
  logic [NRES*RCNTW-1:0] res_cnt_d, res_cnt_q;
  logic [ERRW-1:0]       err_d, err_q;
  logic                  overrun_d, overrun_q;

  logic                  rd_clr, rd_ld1, rd_inc, rd_at_max;
  logic [CNTW-1:0]       rd_w;
  logic                  res_clr, res_ld1_en, res_inc_en, cur_at_max;
  logic [NRES-1:0]       res_ld1, res_inc, res_at_max;
  logic [RCNTW-1:0]      res_w [NRES];

  slope_phase_counter #(.W(CNTW)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (rd_clr),
    .ld1      (rd_ld1),
    .inc      (rd_inc),
    .cnt      (rd_w),
    .at_max_c (rd_at_max)
  );

  for (genvar g = 0; g < NRES; g++) begin : g_res
    slope_phase_counter #(.W(RCNTW)) u_res_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (res_clr),
      .ld1      (res_ld1[g]),
      .inc      (res_inc[g]),
      .cnt      (res_w[g]),
      .at_max_c (res_at_max[g])
    );
  end

  // Next-state, counter control and result-register update.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    err_w_d     = err_w_q;
    rd_clr      = 1'b0;
    rd_ld1      = 1'b0;
    rd_inc      = 1'b0;
    res_clr     = 1'b0;
    res_ld1_en  = 1'b0;
    res_inc_en  = 1'b0;
    out_valid_d = out_valid_q & ~out_ready;
    overrun_d   = overrun_q;
    rd_cnt_d    = rd_cnt_q;
    res_cnt_d   = res_cnt_q;
    err_d       = err_q;

    cur_at_max = 1'b0;
    for (int unsigned k = 0; k < NRES; k++) begin
      if (ph_q == PHW'(k)) cur_at_max = res_at_max[k];
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_clr  = 1'b1;
            res_clr = 1'b1;
            ph_d    = '0;
            if (zero_cmp) begin
              rd_ld1  = 1'b1;
              state_d = S_RUNDOWN;
            end else begin
              err_w_d = ERR_SIGN;
              state_d = S_DONE;
            end
          end
        end
        S_RUNDOWN: begin
          if (zero_cmp) begin
            if (rd_at_max) begin
              err_w_d = ERR_RD_TMO;
              state_d = S_DONE;
            end else begin
              rd_inc = 1'b1;
            end
          end else begin
            ph_d       = '0;
            res_ld1_en = 1'b1;
            state_d    = S_RES;
          end
        end
        S_RES: begin
          if (zero_cmp == cont_level(ph_q)) begin
            if (cur_at_max) begin
              err_w_d = ERRW'(ERR_RES_TMO_BASE + ERRW'(ph_q));
              state_d = S_DONE;
            end else begin
              res_inc_en = 1'b1;
            end
          end else if (ph_q == PHW'(NRES - 1)) begin
            err_w_d = ERR_NONE;
            state_d = S_DONE;
          end else begin
            ph_d       = PHW'(ph_q + PHW'(1));
            res_ld1_en = 1'b1;
          end
        end
        S_DONE: begin
          overrun_d   = overrun_q | (out_valid_q & ~out_ready);
          out_valid_d = 1'b1;
          rd_cnt_d    = rd_w;
          for (int unsigned k = 0; k < NRES; k++) begin
            res_cnt_d[k*RCNTW +: RCNTW] = res_w[k];
          end
          err_d   = err_w_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    for (int unsigned k = 0; k < NRES; k++) begin
      res_ld1[k]  = res_ld1_en && (ph_d == PHW'(k));
      res_inc[k]  = res_inc_en && (ph_q == PHW'(k));
      sw_res_d[k] = (state_d == S_RES) && (ph_d == PHW'(k));
    end
    sw_rundown_d = (state_d == S_RUNDOWN);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      err_w_q      <= ERR_NONE;
      sw_rundown_q <= 1'b0;
      sw_res_q     <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      rd_cnt_q     <= '0;
      res_cnt_q    <= '0;
      err_q        <= ERR_NONE;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      err_w_q      <= err_w_d;
      sw_rundown_q <= sw_rundown_d;
      sw_res_q     <= sw_res_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      rd_cnt_q     <= rd_cnt_d;
      res_cnt_q    <= res_cnt_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sw_rundown = sw_rundown_q;
  assign sw_res     = sw_res_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign rd_cnt     = rd_cnt_q;
  assign res_cnt    = res_cnt_q;
  assign err        = err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_multislope_rundown_seq.sv
// Directed bench for multislope_rundown_seq: table of comparator waveforms
// with hand-computed counts, plus abort and handshake/overrun sequences.
module tb_multislope_rundown_seq;

  localparam int unsigned NRES  = 3;
  localparam int unsigned CNTW  = 12;
  localparam int unsigned RCNTW = 8;
  localparam int          NVEC  = 9;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start, abort, zero_cmp, out_ready;
  logic                  sw_rundown, busy, out_valid, overrun;
  logic [NRES-1:0]       sw_res;
  logic [CNTW-1:0]       rd_cnt;
  logic [NRES*RCNTW-1:0] res_cnt;
  logic [2:0]            err;

  int n_tests = 0;
  int n_fail  = 0;

  // Segment lengths in clock edges: seg0 with zero_cmp=1 (0 = wrong sign at
  // start), then alternating 0/1/0; afterwards zero_cmp returns to 1.
  typedef struct {
    int seg0, seg1, seg2, seg3;
    int rd, r0, r1, r2;
    int err;
    int lat;
  } vec_t;

  vec_t tbl [NVEC];

  multislope_rundown_seq #(.NRES(NRES), .CNTW(CNTW), .RCNTW(RCNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .zero_cmp   (zero_cmp),
    .sw_rundown (sw_rundown),
    .sw_res     (sw_res),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_cnt     (rd_cnt),
    .res_cnt    (res_cnt),
    .err        (err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic lvl(input vec_t v, input int i);
    int c;
    if (v.seg0 == 0) return 1'b0;
    c = v.seg0;
    if (i < c) return 1'b1;
    c += v.seg1;
    if (i < c) return 1'b0;
    c += v.seg2;
    if (i < c) return 1'b1;
    c += v.seg3;
    if (i < c) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pack_res(input int r0, input int r1, input int r2);
    return 32'({8'(r2), 8'(r1), 8'(r0)});
  endfunction

  task automatic run_conv(input vec_t v, input bit rdy_done, input bit consume,
                          input bit exp_ovr, input string tag);
    int edges;
    bit got, sw_seen;
    edges = 0; got = 1'b0; sw_seen = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      start     = (i == 0);
      zero_cmp  = lvl(v, i);
      out_ready = rdy_done && (i == v.lat - 1);
      tick();
      edges = i + 1;
      if (sw_rundown || (|sw_res)) sw_seen = 1'b1;
      if (!busy) got = 1'b1;
    end
    start = 1'b0; out_ready = 1'b0;
    chk({tag, " done"},      32'(got), 32'd1);
    chk({tag, " latency"},   32'(edges), 32'(v.lat));
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " rd_cnt"},    32'(rd_cnt), 32'(v.rd));
    chk({tag, " res_cnt"},   32'(res_cnt), pack_res(v.r0, v.r1, v.r2));
    chk({tag, " err"},       32'(err), 32'(v.err));
    chk({tag, " sw_off"},    32'({sw_rundown, sw_res}), 32'd0);
    chk({tag, " sw_seen"},   32'(sw_seen), 32'(v.seg0 > 0));
    chk({tag, " overrun"},   32'(overrun), 32'(exp_ovr));
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " consumed"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t va, vb, vc;
    bit   any_valid;

    tbl[0] = '{100, 20, 5, 3,   100, 20, 5, 3,     0, 130};
    tbl[1] = '{1, 1, 1, 1,      1, 1, 1, 1,        0, 6};
    tbl[2] = '{0, 0, 0, 0,      0, 0, 0, 0,        1, 2};
    tbl[3] = '{7, 2, 9, 4,      7, 2, 9, 4,        0, 24};
    tbl[4] = '{5000, 0, 0, 0,   4095, 0, 0, 0,     2, 4097};
    tbl[5] = '{2, 400, 0, 0,    2, 255, 0, 0,      3, 259};
    tbl[6] = '{1, 1, 300, 0,    1, 1, 255, 0,      4, 259};
    tbl[7] = '{1, 1, 1, 300,    1, 1, 1, 255,      5, 260};
    tbl[8] = '{3, 254, 1, 1,    3, 254, 1, 1,      0, 261};

    rst = 1'b0; start = 1'b0; abort = 1'b0; zero_cmp = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("rst sw_rundown", 32'(sw_rundown), 32'd0);
    chk("rst sw_res",     32'(sw_res), 32'd0);
    chk("rst busy",       32'(busy), 32'd0);
    chk("rst out_valid",  32'(out_valid), 32'd0);
    chk("rst rd_cnt",     32'(rd_cnt), 32'd0);
    chk("rst res_cnt",    32'(res_cnt), 32'd0);
    chk("rst err",        32'(err), 32'd0);
    chk("rst overrun",    32'(overrun), 32'd0);
    rst = 1'b1;
    tick();

    for (int n = 0; n < NVEC; n++) begin
      run_conv(tbl[n], 1'b0, 1'b1, 1'b0, $sformatf("vec%0d", n));
      tick();
    end

    // Abort in residue phase 0: switches drop, start ignored, no result.
    start = 1'b1; zero_cmp = 1'b1; tick();
    start = 1'b0; zero_cmp = 1'b0; tick();
    chk("abort pre sw_res", 32'(sw_res), 32'b001);
    tick();
    abort = 1'b1; tick();
    chk("abort sw_res",     32'(sw_res), 32'd0);
    chk("abort sw_rundown", 32'(sw_rundown), 32'd0);
    chk("abort busy",       32'(busy), 32'd0);
    start = 1'b1; tick();
    chk("abort start ign",  32'(busy), 32'd0);
    abort = 1'b0; start = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      zero_cmp = i[0];
      tick();
      if (out_valid) any_valid = 1'b1;
    end
    chk("abort no valid", 32'(any_valid), 32'd0);
    chk("abort keep rd",  32'(rd_cnt), 32'(tbl[8].rd));
    chk("abort keep res", 32'(res_cnt), pack_res(tbl[8].r0, tbl[8].r1, tbl[8].r2));
    chk("abort keep err", 32'(err), 32'(tbl[8].err));
    zero_cmp = 1'b1;
    tick();

    // Handshake: ready coinciding with a new result, then a lost result.
    va = '{2, 3, 4, 5,  2, 3, 4, 5,  0, 16};
    vb = '{3, 1, 2, 1,  3, 1, 2, 1,  0, 9};
    vc = '{1, 1, 1, 1,  1, 1, 1, 1,  0, 6};
    run_conv(va, 1'b0, 1'b0, 1'b0, "hs_a");
    tick();
    run_conv(vb, 1'b1, 1'b0, 1'b0, "hs_b");
    tick();
    run_conv(vc, 1'b0, 1'b0, 1'b1, "hs_c");
    tick();
    chk("hold valid", 32'(out_valid), 32'd1);
    chk("hold rd",    32'(rd_cnt), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("ovr drain valid", 32'(out_valid), 32'd0);
    tick();
    chk("ovr sticky", 32'(overrun), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
